// File: rtl/pad_input_filter_pkg.sv
// Shared types and defaults for the pad input conditioning block.
//   CntWidthDefault - default debounce counter / threshold width
//   NumPadsDefault  - default number of pads
//   pad_evt_cfg_t   - per-pad configuration as laid out by the register file
package pad_filter_pkg;

  localparam int CntWidthDefault = 4;
  localparam int NumPadsDefault  = 8;

  typedef struct packed {
    logic rise_en;
    logic fall_en;
    logic filter_en;
  } pad_evt_cfg_t;

endpackage

// File: rtl/pad_input_filter_if.sv
// Bundle of pad-side inputs, configuration and conditioned outputs.
//   master : drives raw pads / config / clears, observes levels, pulses, events
//   slave  : the filter block itself
interface pad_input_filter_if #(
  parameter int NumPads  = 8,
  parameter int CntWidth = 4
);
  logic [NumPads-1:0]  pad_in_i;
  logic [NumPads-1:0]  filter_en_i;
  logic [CntWidth-1:0] filter_thresh_i;
  logic [NumPads-1:0]  rise_en_i;
  logic [NumPads-1:0]  fall_en_i;
  logic [NumPads-1:0]  evt_clr_i;
  logic [NumPads-1:0]  data_o;
  logic [NumPads-1:0]  rise_o;
  logic [NumPads-1:0]  fall_o;
  logic [NumPads-1:0]  evt_o;

  modport master (
    output pad_in_i, filter_en_i, filter_thresh_i, rise_en_i, fall_en_i, evt_clr_i,
    input  data_o, rise_o, fall_o, evt_o
  );

  modport slave (
    input  pad_in_i, filter_en_i, filter_thresh_i, rise_en_i, fall_en_i, evt_clr_i,
    output data_o, rise_o, fall_o, evt_o
  );
endinterface

// File: rtl/pad_input_filter_bit.sv
// One pad: 2-flop synchroniser, consecutive-sample debounce, level register,
// edge pulses and sticky event flag.
//   pad_in_i        raw asynchronous pad value
//   cfg_i           rise/fall event enables and filter enable
//   filter_thresh_i shared debounce threshold
//   evt_clr_i       write-1-to-clear for evt_o
//   data_o/rise_o/fall_o/evt_o  conditioned level, edge pulses, sticky event
module pad_filter_bit
  import pad_filter_pkg::*;
#(
  parameter int CntWidth = CntWidthDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_in_i,
  input  pad_evt_cfg_t        cfg_i,
  input  logic [CntWidth-1:0] filter_thresh_i,
  input  logic                evt_clr_i,
  output logic                data_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                evt_o
);

  logic                s1, s2;
  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] thr;
  logic                evt_set;

  assign thr     = cfg_i.filter_en ? filter_thresh_i : '0;
  assign evt_set = (rise_o & cfg_i.rise_en) | (fall_o & cfg_i.fall_en);

  // cnt counts samples of s2 disagreeing with data_o; it is cleared on any
  // agreement, so the level only moves after T+1 consecutive samples. The >=
  // test lets a lowered threshold take effect on the very next sample, and
  // also keeps cnt from ever exceeding T (no wrap).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      data_o <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      s1     <= pad_in_i;
      s2     <= s1;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (s2 == data_o) begin
        cnt <= '0;
      end else if (cnt >= thr) begin
        data_o <= s2;
        cnt    <= '0;
        rise_o <= s2;
        fall_o <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A new event wins over a coincident clear so no edge is ever lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        evt_o <= 1'b0;
    else if (evt_set)   evt_o <= 1'b1;
    else if (evt_clr_i) evt_o <= 1'b0;
  end

endmodule

// File: rtl/pad_input_filter.sv
// Per-pad input conditioning: NumPads independent pad_filter_bit lanes
// sharing one debounce threshold.
//   clk_i, rst_ni : core clock, async active-low reset
//   bus (slave)   : raw pads, per-pad config, clears; levels, pulses, events
module pad_input_filter
  import pad_filter_pkg::*;
#(
  parameter int NumPads  = NumPadsDefault,
  parameter int CntWidth = CntWidthDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  pad_input_filter_if.slave bus
);

  logic [NumPads-1:0] data, rise, fall, evt;

  for (genvar i = 0; i < NumPads; i++) begin : g_pad
    pad_evt_cfg_t cfg;
    assign cfg = '{rise_en:   bus.rise_en_i[i],
                   fall_en:   bus.fall_en_i[i],
                   filter_en: bus.filter_en_i[i]};

    pad_filter_bit #(.CntWidth(CntWidth)) u_bit (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .pad_in_i        (bus.pad_in_i[i]),
      .cfg_i           (cfg),
      .filter_thresh_i (bus.filter_thresh_i),
      .evt_clr_i       (bus.evt_clr_i[i]),
      .data_o          (data[i]),
      .rise_o          (rise[i]),
      .fall_o          (fall[i]),
      .evt_o           (evt[i])
    );
  end

  assign bus.data_o = data;
  assign bus.rise_o = rise;
  assign bus.fall_o = fall;
  assign bus.evt_o  = evt;

endmodule
